// File: rtl/fetch_prefetch_queue.sv
// ============================================================================
// fetch_prefetch_queue -- instruction fetch unit with credit-limited prefetch
// queue, in-order PC tag FIFO and branch-redirect flush. Rev 1.0
// ============================================================================
`default_nettype none

module fetch_prefetch_queue #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [63:0] if_pc,
  input  logic        id_stall,
  input  logic        br_redirect,
  input  logic [63:0] br_addr
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW        = AW + 1;
  localparam logic [CW:0] DEPTH_W   = (CW + 1)'(DEPTH);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [CW-1:0] count_q, count_d, outst_q, outst_d, discard_q, discard_d;

  logic [63:0]   ent_pc_q    [DEPTH];
  logic [31:0]   ent_instr_q [DEPTH];
  logic [63:0]   tag_pc_q    [DEPTH];

  logic [CW:0]   w_credit_sum;
  logic          w_accept, w_rsp, w_drop, w_push, w_pop;

  // Credits count both buffered and in-flight entries, so a response always
  // finds a free slot.
  assign w_credit_sum = {1'b0, count_q} + {1'b0, outst_q};
  assign imem_req     = rst_n && !br_redirect && (w_credit_sum < DEPTH_W);
  assign imem_addr    = fetch_pc_q;
  assign w_accept     = imem_req && imem_ready;

  assign w_rsp  = imem_rvalid && (outst_q != '0);
  assign w_drop = br_redirect || (discard_q != '0);
  assign w_push = w_rsp && !w_drop;
  assign w_pop  = if_valid && !id_stall && !br_redirect;

  assign if_valid = (count_q != '0);
  assign if_instr = if_valid ? ent_instr_q[head_q] : NOP_INSTR;
  assign if_pc    = if_valid ? ent_pc_q[head_q]    : RESET_PC;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;
    count_d    = count_q + CW'(w_push) - CW'(w_pop);
    outst_d    = outst_q + CW'(w_accept) - CW'(w_rsp);
    discard_d  = discard_q;

    if (w_accept) begin
      fetch_pc_d = fetch_pc_q + 64'd4;
      tag_wr_d   = tag_wr_q + AW'(1);
    end
    if (w_rsp) begin
      tag_rd_d = tag_rd_q + AW'(1);
    end
    if (w_rsp && (discard_q != '0)) begin
      discard_d = discard_q - CW'(1);
    end
    if (w_push) begin
      tail_d = tail_q + AW'(1);
    end
    if (w_pop) begin
      head_d = head_q + AW'(1);
    end

    // Flush: everything still in flight is old-path, except a response that
    // is being dropped right now.
    if (br_redirect) begin
      fetch_pc_d = br_addr;
      head_d     = tail_q;
      tail_d     = tail_q;
      count_d    = '0;
      discard_d  = outst_q - CW'(w_rsp);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      tag_pc_q[tag_wr_q] <= fetch_pc_q;
    end
    if (w_push) begin
      ent_pc_q[tail_q]    <= tag_pc_q[tag_rd_q];
      ent_instr_q[tail_q] <= imem_rdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_prefetch_queue.sv
// ============================================================================
// tb_fetch_prefetch_queue -- directed self-checking bench for the fetch unit.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_prefetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        id_stall = 1'b0;
  logic        br_redirect = 1'b0;
  logic [63:0] br_addr = 64'h0;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  logic [63:0] exp_pc = 64'h0;
  logic [63:0] hold_pc;
  logic [63:0] pend_addr [$];
  int          pend_due  [$];

  fetch_prefetch_queue #(.RESET_PC(64'h0), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .id_stall    (id_stall),
    .br_redirect (br_redirect),
    .br_addr     (br_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ 32'hA5C3_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive_mem();
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(pend_addr[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  endtask

  // One clock cycle: sample the cycle's handshakes, check any pop against the
  // expected PC stream, advance the clock, then update the memory model.
  task automatic tick();
    logic        acc;
    logic        rv;
    logic [63:0] a;
    #1;
    acc = imem_req && imem_ready;
    a   = imem_addr;
    rv  = imem_rvalid;
    chk("push_at_full", 64'(rv && !br_redirect && (int'(dut.discard_q) == 0)
                            && (int'(dut.count_q) == DEPTH)), 64'd0);
    if (if_valid && !id_stall && !br_redirect) begin
      chk("pop_pc", if_pc, exp_pc);
      chk("pop_instr", 64'(if_instr), 64'(word_of(exp_pc)));
      exp_pc += 64'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rv && pend_addr.size() > 0) begin
      pend_addr.delete(0);
      pend_due.delete(0);
    end
    if (acc) begin
      pend_addr.push_back(a);
      pend_due.push_back(cyc - 1 + mem_lat);
    end
    drive_mem();
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!if_valid && n < 30) begin
      tick();
      n++;
    end
    chk(tag, 64'(if_valid), 64'd1);
  endtask

  task automatic redirect(input logic [63:0] target);
    br_redirect = 1'b1;
    br_addr     = target;
    #1;
    chk("req_during_redirect", 64'(imem_req), 64'd0);
    tick();
    br_redirect = 1'b0;
    exp_pc      = target;
    #1;
    chk("empty_after_redirect", 64'(if_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with a stray response on the bus that must be ignored.
    #1 rst_n = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    #1;
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_valid", 64'(if_valid), 64'd0);
    chk("rst_instr", 64'(if_instr), 64'(NOP));
    chk("rst_pc", if_pc, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("first_req", 64'(imem_req), 64'd1);
    chk("first_addr", imem_addr, 64'h0);

    // Streaming with L=1: valid two cycles after the first accept, then one
    // instruction per cycle.
    tick();
    chk("lat_not_yet", 64'(if_valid), 64'd0);
    tick();
    chk("lat_valid", 64'(if_valid), 64'd1);
    chk("lat_pc", if_pc, 64'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("steady_valid", 64'(if_valid), 64'd1);
    end

    // Decode stall: the queue fills to DEPTH and the head holds.
    id_stall = 1'b1;
    hold_pc  = exp_pc;
    repeat (10) tick();
    chk("stall_head_pc", if_pc, hold_pc);
    chk("stall_head_instr", 64'(if_instr), 64'(word_of(hold_pc)));
    chk("stall_req", 64'(imem_req), 64'd0);
    chk("stall_count", 64'(int'(dut.count_q)), 64'(DEPTH));
    chk("stall_outst", 64'(int'(dut.outst_q)), 64'd0);
    id_stall = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_valid", 64'(if_valid), 64'd1);
      tick();
    end

    // L=3 with requests in flight, then redirect to 0x100.
    mem_lat = 3;
    begin
      int n = 0;
      while (pend_addr.size() < 2 && n < 30) begin
        tick();
        n++;
      end
      chk("two_in_flight", 64'(pend_addr.size() >= 2), 64'd1);
    end
    redirect(64'h100);
    chk("redirect_req", 64'(imem_req), 64'd1);
    chk("redirect_addr", imem_addr, 64'h100);
    wait_valid("redirect_arrival");
    chk("redirect_first_pc", if_pc, 64'h100);
    repeat (4) tick();

    // Redirect coincident with a response while decode is stalled.
    mem_lat  = 1;
    id_stall = 1'b1;
    begin
      int n = 0;
      while (!imem_rvalid && n < 20) begin
        tick();
        n++;
      end
      chk("rvalid_seen", 64'(imem_rvalid), 64'd1);
    end
    redirect(64'h200);
    id_stall = 1'b0;
    wait_valid("stall_redirect_arrival");
    chk("stall_redirect_pc", if_pc, 64'h200);
    repeat (3) tick();

    // PC wraps from the top of the address space to zero.
    redirect(64'hFFFF_FFFF_FFFF_FFFC);
    wait_valid("wrap_arrival");
    chk("wrap_top_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("wrap_next_valid", 64'(if_valid), 64'd1);
    chk("wrap_zero_pc", if_pc, 64'h0);
    chk("wrap_zero_instr", 64'(if_instr), 64'(word_of(64'h0)));
    repeat (2) tick();

    // Asynchronous reset with three entries buffered.
    id_stall = 1'b1;
    begin
      int n = 0;
      while (int'(dut.count_q) != 3 && n < 20) begin
        tick();
        n++;
      end
      chk("count_three", 64'(int'(dut.count_q)), 64'd3);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(if_valid), 64'd0);
    chk("async_rst_req", 64'(imem_req), 64'd0);
    chk("async_rst_pc", if_pc, 64'h0);
    chk("async_rst_instr", 64'(if_instr), 64'(NOP));
    pend_addr.delete();
    pend_due.delete();
    imem_rvalid = 1'b0;
    id_stall    = 1'b0;
    exp_pc      = 64'h0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("restart_req", 64'(imem_req), 64'd1);
    chk("restart_addr", imem_addr, 64'h0);
    wait_valid("restart_arrival");
    chk("restart_pc", if_pc, 64'h0);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_prefetch_queue.md
FETCH_PREFETCH_QUEUE -- requirements
Module: fetch_prefetch_queue

Interface
REQ-001 Parameter RESET_PC, default 64'h0: PC of the first fetch after reset.
REQ-002 Parameter DEPTH, default 4: instruction queue entries; power of two, at least 2.
REQ-003 clk  input  1  Single clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  Reset, asynchronous, active-low.
REQ-005 imem_req  output  1  Fetch request valid.
REQ-006 imem_addr  output  64  Fetch byte address; valid while imem_req=1.
REQ-007 imem_ready  input  1  Memory accepts the request this cycle. A request is accepted when imem_req=1 and imem_ready=1 in the same cycle.
REQ-008 imem_rvalid  input  1  Response valid. One response per accepted request, in order, latency of 1 or more cycles.
REQ-009 imem_rdata  input  32  Response instruction word.
REQ-010 if_valid  output  1  Queue head holds a valid instruction for decode.
REQ-011 if_instr  output  32  Instruction at the queue head.
REQ-012 if_pc  output  64  PC of the queue head.
REQ-013 id_stall  input  1  Decode cannot take the head this cycle.
REQ-014 br_redirect  input  1  Taken branch resolved; flush and redirect.
REQ-015 br_addr  input  64  Redirect target; sampled when br_redirect=1.

Function
REQ-016 State: fetch_pc[63:0]; circular queue with head and tail pointers and count (0..DEPTH), each entry holding {pc, instr}; outstanding counter; discard counter.
REQ-017 imem_req=1 when count + outstanding < DEPTH and br_redirect=0; imem_addr=fetch_pc.
REQ-018 On acceptance: fetch_pc advances by 4, modulo 2^64 with no trap at wrap; outstanding increments.
REQ-019 The PC of each accepted request is kept in an in-order tag FIFO of DEPTH entries; a response is pushed into the queue with the popped tag PC.
REQ-020 On imem_rvalid with discard=0: push {tag pc, imem_rdata} at tail; outstanding decrements.
REQ-021 On imem_rvalid with discard>0: drop the response; decrement both discard and outstanding; the tag FIFO is still popped.
REQ-022 The credit rule in REQ-017 guarantees no push when the queue is full; a push at count=DEPTH is a protocol error, and the bench flags it with an assertion.
REQ-023 if_valid = (count != 0). if_instr and if_pc are driven combinationally from the head entry.
REQ-024 Pop when if_valid=1 and id_stall=0. Push and pop in the same cycle leave count unchanged.
REQ-025 While id_stall=1, the head, if_instr and if_pc hold stable; fetching continues until credit is exhausted.
REQ-026 br_redirect=1, next edge:
- count goes to 0 and head equals tail
- fetch_pc becomes br_addr
- discard becomes outstanding minus 1 if a response arrives this cycle, otherwise outstanding
- no request is issued and no pop occurs this cycle
REQ-027 A redirect in the same cycle as a response: that response is dropped and the new discard excludes it.
REQ-028 A redirect while discard>0: discard is recomputed per REQ-026, never summed.
REQ-029 The first post-redirect request is issued the cycle after the redirect if credit allows. Instructions from the old path never appear at the head after the redirect edge.
REQ-030 Latency with imem response latency L: accept at cycle t gives if_valid at t+L+1 when the queue was empty.
REQ-031 if_pc values presented to decode increment by 4 between redirects, with no gaps or duplicates.

Reset
REQ-032 While rst_n=0, independent of clk:
- fetch_pc=RESET_PC
- count, outstanding, discard, head, tail and tag pointers = 0
- imem_req=0, if_valid=0
- if_instr=32'h00000013 (NOP), if_pc=RESET_PC
REQ-033 The first request is issued on the first edge after rst_n rises. Responses arriving during reset are ignored.
REQ-034 Reset mid-operation drops all in-flight state. The bench does not return responses for pre-reset requests.

Verification
REQ-035 Reset, memory with ready=1 and L=1, id_stall=0, RESET_PC=0 -> if_pc sequence 0x0, 0x4, 0x8, ... with one instruction per cycle in steady state.
REQ-036 id_stall=1 for 10 cycles -> exactly DEPTH=4 entries buffered; outstanding=0; imem_req=0; head held; after release, 4 consecutive pops in PC order.
REQ-037 L=3, two requests in flight, br_redirect=1 with br_addr=0x100 -> both old responses dropped; first if_pc after the redirect=0x100.
REQ-038 br_redirect coincident with imem_rvalid and id_stall=1 -> the response is dropped, the queue is empty next cycle, and if_valid=0.
REQ-039 fetch_pc=64'hFFFF_FFFF_FFFF_FFFC -> next if_pc=64'h0.
REQ-040 Assert rst_n=0 mid-stream with queue count=3 -> if_valid=0 and imem_req=0 immediately, without waiting for a clock edge; restart at RESET_PC.
